// File: rtl/clk_div_pkg.sv
// Shared defaults and configuration clamping for the programmable clock divider.
package clk_div_pkg;

  localparam int PKG_CW      = 16;
  localparam int PKG_DEF_DIV = 50;
  localparam int PKG_DEF_HI  = 25;

  // A period shorter than two cycles cannot hold both a high and a low phase.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < 32'd2) ? 32'd2 : div;
  endfunction

  function automatic logic [31:0] clamp_ph(input logic [31:0] ph, input logic [31:0] div);
    return (ph >= div) ? (div - 32'd1) : ph;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow and active config, period counter and
// registered clock/tick/pending outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CW      = PKG_CW,
  parameter int DEF_DIV = PKG_DEF_DIV,
  parameter int DEF_HI  = PKG_DEF_HI
) (
  input  logic          clkI,
  input  logic          nRst,
  input  logic          i_en,
  input  logic          i_sync,
  input  logic          i_wr,
  input  logic [CW-1:0] i_div,
  input  logic [CW-1:0] i_hi,
  input  logic [CW-1:0] i_ph,
  output logic          o_clk,
  output logic          o_tick,
  output logic          o_pend
);

  logic          r_en_d;
  logic [CW-1:0] r_div_a, r_hi_a, r_ph_a;
  logic [CW-1:0] r_div_s, r_hi_s, r_ph_s;
  logic [CW-1:0] r_cnt;
  logic          r_clk, r_tick, r_pend;

  logic          w_at_end, w_apply, w_restart, w_pend_n;
  logic [CW-1:0] w_src_div, w_src_hi, w_src_ph;
  logic [CW-1:0] w_div_n, w_hi_n, w_ph_n, w_cnt_n;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave a value unassigned and infer a latch.
    w_at_end  = (r_cnt == (r_div_a - CW'(1)));
    w_apply   = !i_en || i_sync || w_at_end;
    w_restart = i_en && (i_sync || !r_en_d);

    // A write landing on an apply edge goes straight to the active set.
    w_src_div = i_wr ? i_div : r_div_s;
    w_src_hi  = i_wr ? i_hi  : r_hi_s;
    w_src_ph  = i_wr ? i_ph  : r_ph_s;

    w_div_n  = r_div_a;
    w_hi_n   = r_hi_a;
    w_ph_n   = r_ph_a;
    w_pend_n = r_pend;
    if (w_apply) begin
      w_div_n  = CW'(clamp_div(32'(w_src_div)));
      w_ph_n   = CW'(clamp_ph(32'(w_src_ph), 32'(w_div_n)));
      w_hi_n   = w_src_hi;
      w_pend_n = 1'b0;
    end else if (i_wr) begin
      w_pend_n = 1'b1;
    end

    if (!i_en) begin
      w_cnt_n = '0;
    end else if (w_restart) begin
      w_cnt_n = w_ph_n;
    end else if (w_at_end) begin
      w_cnt_n = '0;
    end else begin
      w_cnt_n = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clkI or negedge nRst) begin
    if (!nRst) begin
      r_en_d  <= 1'b0;
      r_div_a <= CW'(DEF_DIV);
      r_hi_a  <= CW'(DEF_HI);
      r_ph_a  <= '0;
      r_div_s <= CW'(DEF_DIV);
      r_hi_s  <= CW'(DEF_HI);
      r_ph_s  <= '0;
      r_cnt   <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_en_d  <= i_en;
      r_div_a <= w_div_n;
      r_hi_a  <= w_hi_n;
      r_ph_a  <= w_ph_n;
      r_cnt   <= w_cnt_n;
      r_pend  <= w_pend_n;
      // Outputs come from next-state values so they line up with r_cnt.
      r_clk   <= i_en && (w_cnt_n < w_hi_n);
      r_tick  <= i_en && (w_cnt_n == '0);
      if (i_wr) begin
        r_div_s <= i_div;
        r_hi_s  <= i_hi;
        r_ph_s  <= i_ph;
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;
  assign o_pend = r_pend;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock/strobe generator: decodes config writes
// to per-channel strobes and broadcasts sync to every channel.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter  int NCH     = 3,
  parameter  int CW      = PKG_CW,
  parameter  int DEF_DIV = PKG_DEF_DIV,
  parameter  int DEF_HI  = PKG_DEF_HI,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clkI,
  input  logic           nRst,
  input  logic [NCH-1:0] enI,
  input  logic           syncI,
  input  logic           cfgWrI,
  input  logic [CHW-1:0] cfgChI,
  input  logic [CW-1:0]  cfgDivI,
  input  logic [CW-1:0]  cfgHiI,
  input  logic [CW-1:0]  cfgPhI,
  output logic [NCH-1:0] clkO,
  output logic [NCH-1:0] tickO,
  output logic [NCH-1:0] pendO
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    // Channel indices beyond NCH match no strobe, so such writes are dropped.
    logic w_wr;
    assign w_wr = cfgWrI && (32'(cfgChI) == c);

    clk_div_chan #(
      .CW      (CW),
      .DEF_DIV (DEF_DIV),
      .DEF_HI  (DEF_HI)
    ) u_chan (
      .clkI   (clkI),
      .nRst   (nRst),
      .i_en   (enI[c]),
      .i_sync (syncI),
      .i_wr   (w_wr),
      .i_div  (cfgDivI),
      .i_hi   (cfgHiI),
      .i_ph   (cfgPhI),
      .o_clk  (clkO[c]),
      .o_tick (tickO[c]),
      .o_pend (pendO[c])
    );
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Multi-channel programmable clock/strobe generator that replaces fixed-ratio dividers in the motor-control clocking tree. It produces NCH phase-aligned divided clocks plus one-cycle period ticks from the system clock. Each channel has a runtime divisor, high-time and phase offset, updated glitch-free at period boundaries. Typical use is three channels at equal divisor with phase offsets of 0, div/3 and 2·div/3 for three-phase PWM timing.

## Interface
- NCH, 3, number of channels
- CW, 16, counter/config width
- DEF_DIV, 50, reset divisor (50 MHz → 1 MHz)
- DEF_HI, 25, reset high-time in clkI cycles
- clkI  in  1  system clock; all logic rising-edge
- nRst  in  1  reset, asynchronous, active-low
- enI  in  NCH  per-channel enable, level
- syncI  in  1  pulse: restart all enabled channels at their phase
- cfgWrI  in  1  config write strobe
- cfgChI  in  clog2(NCH)  target channel
- cfgDivI  in  CW  divisor (period in clkI cycles)
- cfgHiI  in  CW  high-time in clkI cycles
- cfgPhI  in  CW  phase offset (start count)
- clkO  out  NCH  divided clocks, registered
- tickO  out  NCH  one-cycle pulse per period, registered
- pendO  out  NCH  shadow config waiting to apply

## Operation
- Per channel: active regs divA/hiA/phA, shadow regs divS/hiS/phS, counter cnt (CW bits), flops clkO/tickO/pendO.
- Reset: divA=DEF_DIV, hiA=DEF_HI, phA=0, shadows equal active, cnt=0, clkO=0, tickO=0, pendO=0.
- Write: cfgWrI=1 with cfgChI<NCH loads shadow of that channel, sets pendO. cfgChI≥NCH: ignored, no state change.
- Apply point: channel disabled, or cnt==divA−1 while enabled. At that edge active←shadow, pendO←0.
- Write coinciding with apply point on same channel: write data bypasses directly into active; pendO=0.
- Clamping on apply: div<2 → 2; ph≥div → div−1; hi unclamped (hi=0 → clkO constant 0; hi≥div → constant 1).
- Disabled (enI=0): cnt=0, clkO=0, tickO=0 from the edge sampling enI=0.
- Enable rise (enI=1, previously disabled): cnt←phA (already-applied config), then count.
- Enabled: cnt wraps divA−1 → 0; otherwise +1.
- syncI=1: every enabled channel loads cnt←phA (with apply if pending at that edge); overrides wrap. Disabled channels unaffected.
- Outputs track the counter value held during the same cycle: clkO=(cnt<hiA), tickO=(cnt==0)&en. Both computed from next-state and registered, so glitch-free.

## Timing
- Period = divA clkI cycles; clkO high for hiA cycles starting at cnt=0.
- Enable/sync latency: first cycle after the sampling edge shows cnt=phA, clkO=(phA<hiA), tickO=(phA==0).
- Config latency: takes effect on the first cycle of the next period (cnt=0 with new divA/hiA); never truncates a running period.
- Channel phase relationship is deterministic: with equal div, channel i leads channel 0 by phA_i cycles after a common syncI.
- nRst asserted mid-period: all outputs 0 immediately (async); first count after release starts at cnt=0 only once enI is sampled high.

## Structure
- Package clk_div_pkg: CW default, DEF_DIV/DEF_HI defaults, clamp function for div/ph.
- Sub-module clk_div_chan: one channel (shadow, active, counter, output flops); top instantiates NCH via generate, decodes cfgChI to per-channel write strobe, broadcasts syncI.

## Test plan
- Reset defaults: release nRst, enI=3'b001 → clkO[0] period 50 cycles, high 25, tickO[0] every 50 cycles; pendO=0.
- Three-phase: write div=300, hi=150, ph=0/100/200 to ch0..2 while disabled, enI=7, syncI pulse → rising edges of clkO[1],[2] lag clkO[0] by 200 and 100 cycles (clkO[2] at cnt 200 → leads ch0 by 200); ticks at offsets 0, 200, 100.
- Glitch-free update: ch0 running div=50, write div=10 hi=3 at cnt=20 → pendO[0]=1 until cnt=49 edge, then period 10 high 3; no short pulse.
- Clamping: write div=1 hi=0 ph=7 → applied div=2, ph=1, clkO constant 0, tickO every 2 cycles; hi=5 with div=4 → clkO constant 1.
- Simultaneous: write arriving at cnt=divA−1 edge → new config active on next cycle, pendO stays 0; cfgChI=3 write → no change.
- Async reset mid-period with clkO=1 → clkO, tickO, pendO drop to 0 without clock edge.
